// File: rtl/matinv_pkg.sv
// Shared constants and state encoding for the 5x5 matrix-inverse sequencer.
package matinv_pkg;

    localparam int MATINV_N          = 5;
    localparam int MATINV_NELEM      = MATINV_N * MATINV_N;
    localparam int MATINV_NOUT       = MATINV_NELEM + MATINV_N;
    localparam int MATINV_DW_DEFAULT = 32;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD    = 3'd1,
        S_SETTLE  = 3'd2,
        S_CAPTURE = 3'd3,
        S_DRAIN   = 3'd4
    } matinv_state_t;

endpackage

// File: rtl/matinv_out_mux.sv
// 30:1 result-word select by output index; flags the final word.
module matinv_out_mux
    import matinv_pkg::*;
#(
    parameter int DW = MATINV_DW_DEFAULT
) (
    input  logic [MATINV_NOUT*DW-1:0] res_i,
    input  logic [4:0]                oidx_i,
    output logic [DW-1:0]             word_o,
    output logic                      last_o
);

    always_comb begin
        word_o = '0;
        for (int k = 0; k < MATINV_NOUT; k++) begin
            if (oidx_i == 5'(k)) word_o = res_i[k*DW +: DW];
        end
        last_o = (oidx_i == 5'(MATINV_NOUT - 1));
    end

endmodule

// File: rtl/matinv_seq.sv
// Load / settle / capture / drain sequencer around the combinational matrix-inverse datapath.
// Optional zero-pivot flag enabled by defining MATINV_SINGULAR_CHK_EN.
module matinv_seq
    import matinv_pkg::*;
#(
    parameter int DW            = MATINV_DW_DEFAULT,
    parameter int SETTLE_CYCLES = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic                        abort,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [DW-1:0]               in_data,
    output logic [MATINV_NELEM*DW-1:0]  mat_a,
    input  logic [MATINV_NELEM*DW-1:0]  dp_inv,
    input  logic [MATINV_N*DW-1:0]      dp_pivot,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [DW-1:0]               out_data,
    output logic                        out_last,
    output logic                        busy,
    output logic                        done,
    output logic                        singular
);

    matinv_state_t              state_q, state_d;
    logic [4:0]                 idx_q, idx_d;
    logic [4:0]                 oidx_q, oidx_d;
    logic [7:0]                 cnt_q, cnt_d;
    logic                       done_q, done_d;
    logic [MATINV_NELEM*DW-1:0] mat_q;
    logic [MATINV_NOUT*DW-1:0]  res_q;
    logic                       in_hs, out_hs, start_acc, capture;
    logic                       mux_last;

    assign in_hs     = (state_q == S_LOAD) && in_valid && !abort;
    assign out_hs    = (state_q == S_DRAIN) && out_ready && !abort;
    assign start_acc = (state_q == S_IDLE) && start && !abort;
    assign capture   = (state_q == S_CAPTURE) && !abort;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        oidx_d  = oidx_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        if (abort) begin
            state_d = S_IDLE;
            idx_d   = '0;
            oidx_d  = '0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_d = S_LOAD;
                        idx_d   = '0;
                    end
                end
                S_LOAD: begin
                    if (in_valid) begin
                        idx_d = idx_q + 5'd1;
                        if (idx_q == 5'(MATINV_NELEM - 1)) begin
                            state_d = S_SETTLE;
                            cnt_d   = '0;
                        end
                    end
                end
                S_SETTLE: begin
                    if (cnt_q == 8'(SETTLE_CYCLES - 1)) state_d = S_CAPTURE;
                    else                                cnt_d   = cnt_q + 8'd1;
                end
                S_CAPTURE: begin
                    state_d = S_DRAIN;
                    oidx_d  = '0;
                end
                S_DRAIN: begin
                    if (out_ready) begin
                        oidx_d = oidx_q + 5'd1;
                        if (oidx_q == 5'(MATINV_NOUT - 1)) begin
                            state_d = S_IDLE;
                            done_d  = 1'b1;
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            oidx_q  <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            oidx_q  <= oidx_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    // The matrix bank is frozen outside LOAD so the datapath sees stable inputs through SETTLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mat_q <= '0;
        end else if (in_hs) begin
            for (int k = 0; k < MATINV_NELEM; k++) begin
                if (idx_q == 5'(k)) mat_q[k*DW +: DW] <= in_data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       res_q <= '0;
        else if (capture) res_q <= {dp_pivot, dp_inv};
    end

`ifdef MATINV_SINGULAR_CHK_EN
    logic sing_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)         sing_q <= 1'b0;
        else if (start_acc) sing_q <= 1'b0;
        else if (capture)   sing_q <= (dp_pivot[(MATINV_N-1)*DW +: DW] == '0);
    end

    assign singular = sing_q;
`else
    logic unused_start_acc;
    assign unused_start_acc = start_acc;
    assign singular         = 1'b0;
`endif

    matinv_out_mux #(.DW(DW)) u_out_mux (
        .res_i  (res_q),
        .oidx_i (oidx_q),
        .word_o (out_data),
        .last_o (mux_last)
    );

    assign in_ready  = (state_q == S_LOAD);
    assign out_valid = (state_q == S_DRAIN);
    assign out_last  = out_valid && mux_last;
    assign busy      = (state_q != S_IDLE);
    assign done      = done_q;
    assign mat_a     = mat_q;

endmodule

// File: doc/matinv_seq.md
# matinv_seq

Sequencer for the combinational 5x5 fraction-free matrix-inverse datapath. It does four things:
- Loads 25 elements serially into a matrix register bank that drives the datapath inputs.
- Holds those inputs stable for a programmable settle window, since the datapath is a deep multicycle path.
- Captures the 25 inverse numerators and 5 pivots.
- Streams the 30 results out over a valid/ready port.

It sits between the host stream fabric and the datapath instance.

## Interface
Parameters:
- DW, 32, element width; matches datapath port width.
- SETTLE_CYCLES, 8, cycles inputs are held before capture; legal range 1..255.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  begin a job; honoured only in IDLE.
- abort  in  1  synchronous abort to IDLE from any state.
- in_valid  in  1  input element valid.
- in_ready  out  1  high only in LOAD.
- in_data  in  DW  element, row-major a11,a12..a55.
- mat_a  out  25*DW  matrix bank to datapath; element k at [k*DW +: DW], k=0 is a11.
- dp_inv  in  25*DW  datapath inverse outputs, same packing (i11..i55).
- dp_pivot  in  5*DW  datapath pivot1..pivot5, pivot1 at LSB.
- out_valid  out  1  result valid, high only in DRAIN.
- out_ready  in  1  downstream accept.
- out_data  out  DW  result word.
- out_last  out  1  high with word index 29.
- busy  out  1  state != IDLE.
- done  out  1  one-cycle pulse after the final output handshake.
- singular  out  1  final pivot was zero at capture.

## Operation
- States are IDLE, LOAD, SETTLE, CAPTURE, DRAIN.
- IDLE: start=1 moves to LOAD; load index cleared.
- LOAD: each in_valid&in_ready writes in_data to bank[idx] and increments idx. The handshake at idx=24 moves to SETTLE with settle count cleared.
- SETTLE: mat_a is not written. Count runs to SETTLE_CYCLES-1, then goes to CAPTURE.
- CAPTURE: registers dp_inv and dp_pivot into a 30-word result bank in one cycle. Moves to DRAIN with the output index cleared.
- DRAIN: out_data = result[oidx]. Order is i11..i55 (oidx 0..24), then pivot1..pivot5 (oidx 25..29).
- Each out_valid&out_ready increments oidx. The handshake at oidx=29 moves to IDLE and pulses done next cycle.
- out_data and out_last are stable while out_valid&!out_ready.
- start outside IDLE is ignored. in_data is not consumed outside LOAD.
- abort has priority over every transition and moves to IDLE next cycle:
  - counters are cleared;
  - the matrix and result banks are kept;
  - done is not pulsed;
  - singular is unchanged.
- abort and start in the same IDLE cycle: abort wins, and the FSM stays in IDLE.
- Arithmetic: no arithmetic on element data; results pass through unmodified.
- Counter widths: indices are 5 bits, settle count is 8 bits.

## Timing
- Reset (async, rst_n=0) sets the following; outputs take these values immediately:
  - state IDLE;
  - all counters 0;
  - matrix and result banks 0;
  - in_ready, out_valid, out_last, busy, done, singular all 0.
- start sampled at edge t: busy=1 and in_ready=1 from t+1.
- From the 25th load handshake to the first out_valid: SETTLE_CYCLES + 1 cycles.
- With out_ready held high, a full drain takes 30 cycles.
- Minimum job length with both streams unstalled: 1 + 25 + SETTLE_CYCLES + 1 + 30 cycles.
- done is high for exactly one cycle, coincident with the return to IDLE (busy=0).
- Reset mid-job discards the job with no partial outputs.

## Configuration
- MATINV_SINGULAR_CHK_EN defined:
  - At CAPTURE, singular is set to (dp_pivot[4] == 0).
  - singular is held until the next accepted start, which clears it.
  - A singular job still drains all 30 words.
- MATINV_SINGULAR_CHK_EN undefined: singular is tied 0 and no comparator is built.

## Structure
- Package matinv_pkg holds:
  - MATINV_N=5, MATINV_NELEM=25, MATINV_NOUT=30;
  - the state enum matinv_state_t;
  - default DW.
- Sub-module matinv_out_mux: 30:1 combinational word select from the result bank by oidx, also producing out_last.

## Test plan
The bench uses a datapath stub with dp_inv element k = mat_a element k + 1000, and pivot p = 100+p (pivot5 stub value programmable).
- Load values 1..25 with no stalls, SETTLE_CYCLES=8 -> out_data sequence 1001..1025, then 101..105; out_last only on 105; done one cycle; total latency 65 cycles from start.
- Random in_valid gaps and out_ready drops (50%) -> same 30-word sequence; out_data stable on every stalled cycle.
- Stub pivot5=0 with MATINV_SINGULAR_CHK_EN -> singular=1 after CAPTURE, all 30 words still emitted; next start clears singular. Without the macro -> singular stays 0.
- abort after 10 loads -> IDLE next cycle, no done, in_ready=0; new job of 25 loads produces correct full output.
- rst_n low during DRAIN at oidx=12 -> all outputs 0 immediately; following job correct.
- start pulsed during SETTLE and DRAIN -> ignored; in_ready stays 0 outside LOAD.
